// File: rtl/alu_ctrl_decoder_if.sv
// ID-to-EX ALU-control bus: decode inputs from ID and the registered EX-side control fields.
// The master modport drives the ID side; the slave modport is the decoder.
interface alu_ctrl_decoder_if #(
   parameter int unsigned CNT_WIDTH = 8
);
   logic [31:0]          i_instr_ID;
   logic                 i_valid_ID;
   logic                 i_stall_ID;
   logic                 i_flush_EX;
   logic [4:0]           o_alu_ctrl_EX;
   logic                 o_valid_EX;
   logic                 o_illegal_EX;
   logic                 o_is_branch_EX;
   logic [CNT_WIDTH-1:0] o_illegal_cnt_EX;

   modport master (
      output i_instr_ID, i_valid_ID, i_stall_ID, i_flush_EX,
      input  o_alu_ctrl_EX, o_valid_EX, o_illegal_EX, o_is_branch_EX, o_illegal_cnt_EX
   );

   modport slave (
      input  i_instr_ID, i_valid_ID, i_stall_ID, i_flush_EX,
      output o_alu_ctrl_EX, o_valid_EX, o_illegal_EX, o_is_branch_EX, o_illegal_cnt_EX
   );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// RV32I ALU-control decoder owning the ALU-control field of the ID/EX register.
// Define ALU_CTRL_DEC_ILLEGAL_CNT_EN to build the saturating illegal-instruction counter.
module alu_ctrl_decoder #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input logic                i_clk,
   input logic                i_rst,
   alu_ctrl_decoder_if.slave  bus
);
   typedef enum logic [4:0] {
      AluAnd = 5'd0, AluOr = 5'd1, AluXor = 5'd2, AluAdd = 5'd3, AluSub = 5'd4,
      AluSll = 5'd5, AluSrl = 5'd6, AluSlt = 5'd7, AluSltu = 5'd8, AluSra = 5'd9,
      AluBeq = 5'd10, AluBne = 5'd11, AluBlt = 5'd12, AluBltu = 5'd13, AluBge = 5'd14,
      AluBgeu = 5'd15, AluLui = 5'd16, AluAuipc = 5'd17, AluFence = 5'd18,
      AluEcall = 5'd19, AluEbreak = 5'd20
   } alu_op_e;

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   alu_op_e    dec_ctrl;
   logic       dec_illegal;
   logic       dec_branch;
   logic       load_en;

   logic [4:0] ctrl_q;
   logic       valid_q, illegal_q, branch_q;

   assign op = bus.i_instr_ID[6:0];
   assign f3 = bus.i_instr_ID[14:12];
   assign f7 = bus.i_instr_ID[31:25];

   always_comb begin
      dec_ctrl    = AluAdd;
      dec_illegal = 1'b0;
      case (op)
         7'b0110011: begin
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  dec_ctrl = AluAdd;
                  3'b001:  dec_ctrl = AluSll;
                  3'b010:  dec_ctrl = AluSlt;
                  3'b011:  dec_ctrl = AluSltu;
                  3'b100:  dec_ctrl = AluXor;
                  3'b101:  dec_ctrl = AluSrl;
                  3'b110:  dec_ctrl = AluOr;
                  default: dec_ctrl = AluAnd;
               endcase
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               dec_ctrl = AluSub;
            end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
               dec_ctrl = AluSra;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         7'b0010011: begin
            case (f3)
               3'b000: dec_ctrl = AluAdd;
               3'b010: dec_ctrl = AluSlt;
               3'b011: dec_ctrl = AluSltu;
               3'b100: dec_ctrl = AluXor;
               3'b110: dec_ctrl = AluOr;
               3'b111: dec_ctrl = AluAnd;
               3'b001: begin
                  if (f7 == 7'b0000000) dec_ctrl = AluSll;
                  else                  dec_illegal = 1'b1;
               end
               default: begin
                  if (f7 == 7'b0000000)      dec_ctrl = AluSrl;
                  else if (f7 == 7'b0100000) dec_ctrl = AluSra;
                  else                       dec_illegal = 1'b1;
               end
            endcase
         end
         7'b0000011, 7'b0100011, 7'b1101111: dec_ctrl = AluAdd;
         7'b1100111: dec_illegal = (f3 != 3'b000);
         7'b1100011: begin
            case (f3)
               3'b000:  dec_ctrl = AluBeq;
               3'b001:  dec_ctrl = AluBne;
               3'b100:  dec_ctrl = AluBlt;
               3'b101:  dec_ctrl = AluBge;
               3'b110:  dec_ctrl = AluBltu;
               3'b111:  dec_ctrl = AluBgeu;
               default: dec_illegal = 1'b1;
            endcase
         end
         7'b0110111: dec_ctrl = AluLui;
         7'b0010111: dec_ctrl = AluAuipc;
         7'b0001111: dec_ctrl = AluFence;
         7'b1110011: begin
            if (bus.i_instr_ID == 32'h0000_0073)      dec_ctrl = AluEcall;
            else if (bus.i_instr_ID == 32'h0010_0073) dec_ctrl = AluEbreak;
            else                                      dec_illegal = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      // Illegal decodes always fall back to ADD.
      if (dec_illegal) dec_ctrl = AluAdd;
   end

   assign dec_branch = (dec_ctrl >= AluBeq) && (dec_ctrl <= AluBgeu);
   assign load_en    = !bus.i_flush_EX && !bus.i_stall_ID && bus.i_valid_ID;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ctrl_q    <= 5'd0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         branch_q  <= 1'b0;
      end else if (bus.i_flush_EX || (!bus.i_stall_ID && !bus.i_valid_ID)) begin
         ctrl_q    <= 5'd0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         branch_q  <= 1'b0;
      end else if (load_en) begin
         ctrl_q    <= dec_ctrl;
         valid_q   <= 1'b1;
         illegal_q <= dec_illegal;
         branch_q  <= dec_branch;
      end
   end

   assign bus.o_alu_ctrl_EX  = ctrl_q;
   assign bus.o_valid_EX     = valid_q;
   assign bus.o_illegal_EX   = illegal_q;
   assign bus.o_is_branch_EX = branch_q;

`ifdef ALU_CTRL_DEC_ILLEGAL_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (load_en && dec_illegal && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign bus.o_illegal_cnt_EX = cnt_q;
`else
   assign bus.o_illegal_cnt_EX = '0;
`endif
endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Randomized bench for alu_ctrl_decoder against a table-driven RV32I decode model.
module tb_alu_ctrl_decoder;
   localparam int unsigned CntW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_ctrl_decoder_if #(.CNT_WIDTH(CntW)) bus ();

   alu_ctrl_decoder #(.CNT_WIDTH(CntW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [6:0] op;
      int         f3;   // -1: don't care
      int         f7;   // -1: don't care
      int         code;
   } rule_t;

   rule_t rules[$];
   int    n_checks = 0;
   int    n_errors = 0;

   int exp_ctrl = 0;
   int exp_valid = 0;
   int exp_illegal = 0;
   int exp_cnt = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void add_rule(input logic [6:0] op, input int f3, input int f7,
                                    input int code);
      rule_t r;
      r.op = op; r.f3 = f3; r.f7 = f7; r.code = code;
      rules.push_back(r);
   endfunction

   // Returns the control code, or -1 for an illegal encoding.
   function automatic int ref_decode(input logic [31:0] instr);
      int f3 = int'(instr[14:12]);
      int f7 = int'(instr[31:25]);
      if (instr[6:0] == 7'b1110011) begin
         if (instr == 32'h0000_0073) return 19;
         if (instr == 32'h0010_0073) return 20;
         return -1;
      end
      foreach (rules[i]) begin
         if (rules[i].op == instr[6:0] && (rules[i].f3 < 0 || rules[i].f3 == f3) &&
             (rules[i].f7 < 0 || rules[i].f7 == f7))
            return rules[i].code;
      end
      return -1;
   endfunction

   task automatic build_rules();
      int r_codes[8] = '{3, 5, 7, 8, 2, 6, 1, 0};
      int i_codes[8] = '{3, -1, 7, 8, 2, -1, 1, 0};
      int b_codes[8] = '{10, 11, -1, -1, 12, 14, 13, 15};
      for (int k = 0; k < 8; k++) begin
         add_rule(7'b0110011, k, 0, r_codes[k]);
         if (i_codes[k] >= 0) add_rule(7'b0010011, k, -1, i_codes[k]);
         if (b_codes[k] >= 0) add_rule(7'b1100011, k, -1, b_codes[k]);
      end
      add_rule(7'b0110011, 0, 32, 4);
      add_rule(7'b0110011, 5, 32, 9);
      add_rule(7'b0010011, 1, 0, 5);
      add_rule(7'b0010011, 5, 0, 6);
      add_rule(7'b0010011, 5, 32, 9);
      add_rule(7'b0000011, -1, -1, 3);
      add_rule(7'b0100011, -1, -1, 3);
      add_rule(7'b1101111, -1, -1, 3);
      add_rule(7'b1100111, 0, -1, 3);
      add_rule(7'b0110111, -1, -1, 16);
      add_rule(7'b0010111, -1, -1, 17);
      add_rule(7'b0001111, -1, -1, 18);
   endtask

   task automatic model_reset();
      exp_ctrl = 0; exp_valid = 0; exp_illegal = 0; exp_cnt = 0;
   endtask

   task automatic check_outputs(input string pfx);
      int br = (exp_valid != 0 && exp_ctrl >= 10 && exp_ctrl <= 15) ? 1 : 0;
      check_eq({pfx, ".ctrl"}, int'(bus.o_alu_ctrl_EX), exp_ctrl);
      check_eq({pfx, ".valid"}, int'(bus.o_valid_EX), exp_valid);
      check_eq({pfx, ".illegal"}, int'(bus.o_illegal_EX), exp_illegal);
      check_eq({pfx, ".is_branch"}, int'(bus.o_is_branch_EX), br);
      check_eq({pfx, ".cnt"}, int'(bus.o_illegal_cnt_EX), exp_cnt);
   endtask

   // Inputs are held from #1 after the previous edge; model follows the edge, check at #1.
   task automatic step(input string pfx);
      int code;
      @(posedge clk);
      if (bus.i_flush_EX) begin
         exp_ctrl = 0; exp_valid = 0; exp_illegal = 0;
      end else if (!bus.i_stall_ID) begin
         if (!bus.i_valid_ID) begin
            exp_ctrl = 0; exp_valid = 0; exp_illegal = 0;
         end else begin
            code = ref_decode(bus.i_instr_ID);
            exp_valid = 1;
            exp_illegal = (code < 0) ? 1 : 0;
            exp_ctrl = (code < 0) ? 3 : code;
`ifdef ALU_CTRL_DEC_ILLEGAL_CNT_EN
            if (code < 0 && exp_cnt < (1 << CntW) - 1) exp_cnt++;
`endif
         end
      end
      #1;
      check_outputs(pfx);
   endtask

   task automatic drive(input logic [31:0] instr, input logic v, input logic s, input logic f);
      bus.i_instr_ID = instr;
      bus.i_valid_ID = v;
      bus.i_stall_ID = s;
      bus.i_flush_EX = f;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops[12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h63, 7'h37,
                              7'h17, 7'h0f, 7'h73, 7'h00};
      logic [31:0] w = $urandom;
      int sel = $urandom_range(0, 11);
      w[6:0] = (sel == 11) ? 7'($urandom) : ops[sel];
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         default: ;
      endcase
      if (sel == 10 && $urandom_range(0, 1) == 1)
         w = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
      return w;
   endfunction

   initial begin
      build_rules();
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_outputs("reset");

      drive(32'h002081B3, 1'b1, 1'b0, 1'b0); step("add");
      check_eq("add.code", int'(bus.o_alu_ctrl_EX), 3);
      #1 drive(32'h402081B3, 1'b1, 1'b0, 1'b0); step("sub");
      check_eq("sub.code", int'(bus.o_alu_ctrl_EX), 4);
      #1 drive(32'h4030D093, 1'b1, 1'b0, 1'b0); step("srai");
      check_eq("srai.code", int'(bus.o_alu_ctrl_EX), 9);
      #1 drive(32'h0020F463, 1'b1, 1'b0, 1'b0); step("bgeu");
      check_eq("bgeu.code", int'(bus.o_alu_ctrl_EX), 15);
      check_eq("bgeu.br", int'(bus.o_is_branch_EX), 1);
      #1 drive(32'h00000073, 1'b1, 1'b0, 1'b0); step("ecall");
      check_eq("ecall.code", int'(bus.o_alu_ctrl_EX), 19);
      #1 drive(32'h022081B3, 1'b1, 1'b0, 1'b0); step("mul");
      check_eq("mul.illegal", int'(bus.o_illegal_EX), 1);

      #1 drive(32'h002081B3, 1'b1, 1'b0, 1'b0); step("stall.load");
      for (int k = 0; k < 3; k++) begin
         #1 drive(32'h402081B3, 1'b1, 1'b1, 1'b0); step("stall.hold");
         check_eq("stall.code", int'(bus.o_alu_ctrl_EX), 3);
      end
      #1 drive(32'h402081B3, 1'b1, 1'b1, 1'b1); step("stall_flush");
      check_eq("stall_flush.valid", int'(bus.o_valid_EX), 0);
      #1 drive(32'h0020F463, 1'b0, 1'b0, 1'b0); step("invalid");
      check_eq("invalid.br", int'(bus.o_is_branch_EX), 0);

      // Asynchronous reset between edges, first while loaded then while stalled.
      #1 drive(32'h0020F463, 1'b1, 1'b0, 1'b0); step("pre_rst");
      #1 drive(32'h0020F463, 1'b1, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 model_reset();
      check_outputs("async_rst");
      #1 rst = 1'b0;
      drive(32'h402081B3, 1'b1, 1'b0, 1'b0); step("post_rst");
      check_eq("post_rst.code", int'(bus.o_alu_ctrl_EX), 4);

      for (int k = 0; k < 2000; k++) begin
         #1 drive(rand_instr(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 9) == 0));
         step("rand");
      end

      for (int k = 0; k < 300; k++) begin
         #1 drive(32'h022081B3, 1'b1, 1'b0, 1'b0); step("sat");
      end
`ifdef ALU_CTRL_DEC_ILLEGAL_CNT_EN
      check_eq("sat.cnt", int'(bus.o_illegal_cnt_EX), 255);
`else
      check_eq("sat.cnt", int'(bus.o_illegal_cnt_EX), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
